// File: rtl/sad_window_scanner.sv
// Row-major window address generator for the SAD datapath: one read address per accepted beat.
// Optional geometry check (MemWidth > FrameWidth) enabled by defining SAD_SCAN_BOUNDS_CHECK_EN.
module sad_window_scanner #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned STRIDE = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [ADDR_W-1:0] MemWidth,
  input  logic [ADDR_W-1:0] MemHeight,
  input  logic [ADDR_W-1:0] FrameWidth,
  input  logic              Stall,
  output logic [ADDR_W-1:0] Addr,
  output logic              AddrValid,
  output logic              LastCol,
  output logic              LastAddr,
  output logic              Busy,
  output logic              Done,
  output logic              GeomErr
);

  localparam int unsigned       StrideShift = $clog2(STRIDE);
  localparam logic [ADDR_W-1:0] StrideInc   = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] One         = ADDR_W'(1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] width_q, height_q, pitch_q, row_base_q, col_q, row_q, addr_q;
  logic              valid_q, last_col_q, last_addr_q, busy_q, done_q, geom_err_q;

  logic              accept, zero_size, geom_bad;
  logic [ADDR_W-1:0] col_nxt, row_nxt, row_base_nxt;
  logic              col_nxt_last, row_wrap_last_col;

  always_comb begin
    accept            = valid_q & ~Stall;
    zero_size         = (MemWidth == '0) || (MemHeight == '0);
`ifdef SAD_SCAN_BOUNDS_CHECK_EN
    geom_bad          = (MemWidth > FrameWidth);
`else
    geom_bad          = 1'b0;
`endif
    col_nxt           = col_q + One;
    row_nxt           = row_q + One;
    row_base_nxt      = row_base_q + pitch_q;
    col_nxt_last      = (col_nxt == width_q - One);
    // After a row wrap col restarts at 0, so LastCol depends only on width.
    row_wrap_last_col = (width_q == One);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      width_q     <= '0;
      height_q    <= '0;
      pitch_q     <= '0;
      row_base_q  <= '0;
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      valid_q     <= 1'b0;
      last_col_q  <= 1'b0;
      last_addr_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      geom_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (Start) begin
            width_q    <= MemWidth;
            height_q   <= MemHeight;
            pitch_q    <= FrameWidth << StrideShift;
            row_base_q <= BaseAddr;
            addr_q     <= BaseAddr;
            col_q      <= '0;
            row_q      <= '0;
            busy_q     <= 1'b1;
            geom_err_q <= geom_bad;
            if (zero_size || geom_bad) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q     <= StScan;
              valid_q     <= 1'b1;
              last_col_q  <= (MemWidth == One);
              last_addr_q <= (MemWidth == One) && (MemHeight == One);
            end
          end
        end
        StScan: begin
          if (accept) begin
            if (last_addr_q) begin
              state_q     <= StDone;
              valid_q     <= 1'b0;
              last_col_q  <= 1'b0;
              last_addr_q <= 1'b0;
              done_q      <= 1'b1;
            end else if (last_col_q) begin
              row_base_q  <= row_base_nxt;
              addr_q      <= row_base_nxt;
              col_q       <= '0;
              row_q       <= row_nxt;
              last_col_q  <= row_wrap_last_col;
              last_addr_q <= row_wrap_last_col && (row_nxt == height_q - One);
            end else begin
              addr_q      <= addr_q + StrideInc;
              col_q       <= col_nxt;
              last_col_q  <= col_nxt_last;
              last_addr_q <= col_nxt_last && (row_q == height_q - One);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Addr      = addr_q;
  assign AddrValid = valid_q;
  assign LastCol   = last_col_q;
  assign LastAddr  = last_addr_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign GeomErr   = geom_err_q;

endmodule

// File: tb/tb_sad_window_scanner.sv
// Directed bench for sad_window_scanner; outputs sampled on the falling edge, inputs driven there too.
module tb_sad_window_scanner;

  logic        Clk = 1'b0;
  logic        Reset, Start, Stall;
  logic [31:0] BaseAddr, MemWidth, MemHeight, FrameWidth;
  logic [31:0] Addr;
  logic        AddrValid, LastCol, LastAddr, Busy, Done, GeomErr;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] c1_addr [6] = '{32'h100, 32'h104, 32'h108, 32'h120, 32'h124, 32'h128};
  logic        c1_lc   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        c1_la   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  sad_window_scanner #(.ADDR_W(32), .STRIDE(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .BaseAddr   (BaseAddr),
    .MemWidth   (MemWidth),
    .MemHeight  (MemHeight),
    .FrameWidth (FrameWidth),
    .Stall      (Stall),
    .Addr       (Addr),
    .AddrValid  (AddrValid),
    .LastCol    (LastCol),
    .LastAddr   (LastAddr),
    .Busy       (Busy),
    .Done       (Done),
    .GeomErr    (GeomErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Pulse Start for one cycle; returns at the falling edge of the first cycle after Start.
  task automatic do_start(input logic [31:0] base, input logic [31:0] w, input logic [31:0] h,
                          input logic [31:0] fw);
    BaseAddr   = base;
    MemWidth   = w;
    MemHeight  = h;
    FrameWidth = fw;
    Start      = 1'b1;
    @(negedge Clk);
    Start      = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_addr"}, Addr, 32'h0);
    check({tag, "_valid"}, {31'b0, AddrValid}, 32'd0);
    check({tag, "_lc"}, {31'b0, LastCol}, 32'd0);
    check({tag, "_la"}, {31'b0, LastAddr}, 32'd0);
    check({tag, "_busy"}, {31'b0, Busy}, 32'd0);
    check({tag, "_done"}, {31'b0, Done}, 32'd0);
    check({tag, "_gerr"}, {31'b0, GeomErr}, 32'd0);
  endtask

  // Walk the W=3,H=2,FW=8,Base=0x100 window; optional stall window and mid-scan input pokes.
  task automatic run_c1(input string tag, input int stall_at, input int stall_n, input bit poke);
    for (int i = 0; i < 6; i++) begin
      if (i == stall_at) begin
        Stall = 1'b1;
        for (int s = 0; s < stall_n; s++) begin
          check({tag, "_hold_addr"}, Addr, c1_addr[i]);
          check({tag, "_hold_valid"}, {31'b0, AddrValid}, 32'd1);
          @(negedge Clk);
        end
        Stall = 1'b0;
      end
      check({tag, "_addr"}, Addr, c1_addr[i]);
      check({tag, "_valid"}, {31'b0, AddrValid}, 32'd1);
      check({tag, "_lc"}, {31'b0, LastCol}, {31'b0, c1_lc[i]});
      check({tag, "_la"}, {31'b0, LastAddr}, {31'b0, c1_la[i]});
      check({tag, "_busy"}, {31'b0, Busy}, 32'd1);
      check({tag, "_nodone"}, {31'b0, Done}, 32'd0);
      if (poke && i == 2) begin
        Start      = 1'b1;
        BaseAddr   = 32'h500;
        MemWidth   = 32'd7;
        MemHeight  = 32'd9;
        FrameWidth = 32'd1;
      end
      if (poke && i == 3) Start = 1'b0;
      @(negedge Clk);
    end
    check({tag, "_done"}, {31'b0, Done}, 32'd1);
    check({tag, "_done_busy"}, {31'b0, Busy}, 32'd1);
    check({tag, "_done_valid"}, {31'b0, AddrValid}, 32'd0);
    @(negedge Clk);
    check({tag, "_post_done"}, {31'b0, Done}, 32'd0);
    check({tag, "_post_busy"}, {31'b0, Busy}, 32'd0);
  endtask

  task automatic run_zero(input string tag, input logic [31:0] w, input logic [31:0] h);
    do_start(32'h200, w, h, 32'd8);
    check({tag, "_done"}, {31'b0, Done}, 32'd1);
    check({tag, "_busy"}, {31'b0, Busy}, 32'd1);
    check({tag, "_valid"}, {31'b0, AddrValid}, 32'd0);
    @(negedge Clk);
    check({tag, "_busy_off"}, {31'b0, Busy}, 32'd0);
    check({tag, "_done_off"}, {31'b0, Done}, 32'd0);
    check({tag, "_valid_off"}, {31'b0, AddrValid}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Stall = 1'b0;
    BaseAddr = '0; MemWidth = '0; MemHeight = '0; FrameWidth = '0;
    // Start coincident with Reset must be ignored.
    @(negedge Clk);
    BaseAddr = 32'h100; MemWidth = 32'd3; MemHeight = 32'd2; FrameWidth = 32'd8; Start = 1'b1;
    @(negedge Clk);
    check_idle_outputs("reset");
    Start = 1'b0; Reset = 1'b0;
    @(negedge Clk);
    check_idle_outputs("post_reset");

    do_start(32'h100, 32'd3, 32'd2, 32'd8);
    run_c1("c1", -1, 0, 1'b0);

    do_start(32'h100, 32'd3, 32'd2, 32'd8);
    run_c1("c2_stall", 1, 3, 1'b0);

    run_zero("c3_w0", 32'd0, 32'd5);
    run_zero("c3_h0", 32'd4, 32'd0);

    do_start(32'h100, 32'd3, 32'd2, 32'd8);
    run_c1("c4_poke", -1, 0, 1'b1);

    // Reset while the 4th beat is presented.
    do_start(32'h100, 32'd3, 32'd2, 32'd8);
    for (int i = 0; i < 3; i++) begin
      check("c5_pre_addr", Addr, c1_addr[i]);
      @(negedge Clk);
    end
    check("c5_beat4", Addr, 32'h120);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check_idle_outputs("c5_rst");
    @(negedge Clk);
    check("c5_no_done", {31'b0, Done}, 32'd0);
    check("c5_no_valid", {31'b0, AddrValid}, 32'd0);
    do_start(32'h100, 32'd3, 32'd2, 32'd8);
    run_c1("c5_rescan", -1, 0, 1'b0);

`ifdef SAD_SCAN_BOUNDS_CHECK_EN
    do_start(32'h0, 32'd10, 32'd2, 32'd8);
    check("c6_done", {31'b0, Done}, 32'd1);
    check("c6_gerr", {31'b0, GeomErr}, 32'd1);
    check("c6_valid", {31'b0, AddrValid}, 32'd0);
    @(negedge Clk);
    check("c6_gerr_hold", {31'b0, GeomErr}, 32'd1);
    check("c6_idle_valid", {31'b0, AddrValid}, 32'd0);
    do_start(32'h100, 32'd3, 32'd2, 32'd8);
    check("c6_gerr_clear", {31'b0, GeomErr}, 32'd0);
    run_c1("c6_after", -1, 0, 1'b0);
`else
    do_start(32'h0, 32'd10, 32'd2, 32'd8);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 10; c++) begin
        check("c6_addr", Addr, 32'(r * 32 + c * 4));
        check("c6_valid", {31'b0, AddrValid}, 32'd1);
        check("c6_lc", {31'b0, LastCol}, (c == 9) ? 32'd1 : 32'd0);
        check("c6_la", {31'b0, LastAddr}, (c == 9 && r == 1) ? 32'd1 : 32'd0);
        check("c6_gerr", {31'b0, GeomErr}, 32'd0);
        @(negedge Clk);
      end
    end
    check("c6_done", {31'b0, Done}, 32'd1);
    @(negedge Clk);
`endif

    do_start(32'hFFFF_FFFC, 32'd2, 32'd1, 32'd8);
    check("c7_addr0", Addr, 32'hFFFF_FFFC);
    check("c7_lc0", {31'b0, LastCol}, 32'd0);
    @(negedge Clk);
    check("c7_addr1", Addr, 32'h0000_0000);
    check("c7_lc1", {31'b0, LastCol}, 32'd1);
    check("c7_la1", {31'b0, LastAddr}, 32'd1);
    @(negedge Clk);
    check("c7_done", {31'b0, Done}, 32'd1);
    check("c7_valid", {31'b0, AddrValid}, 32'd0);
    @(negedge Clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
